// File: rtl/seq_alu_pkg.sv
// Shared opcodes, flag bit positions and FSM encoding for seq_alu.
// The MULT state exists only when SEQ_ALU_MUL_EN is defined.
package seq_alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_ADC = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_SBB = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8;
    localparam logic [3:0] OP_SHR = 4'd9;
    localparam logic [3:0] OP_MUL = 4'd10;
    localparam logic [3:0] OP_CMP = 4'd11;

    localparam int FLAG_CF = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_NF = 1;
    localparam int FLAG_ZF = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIN  = 2'd1
`ifdef SEQ_ALU_MUL_EN
        ,
        MULT = 2'd2
`endif
    } state_t;

    // Single-cycle ops that load the flag register (MUL is handled separately).
    function automatic logic op_writes_flags(input logic [3:0] op);
        return (op <= OP_SHR) || (op == OP_CMP);
    endfunction

endpackage

// File: rtl/seq_alu_mul.sv
// Shift-add unsigned multiplier: load captures operands, each step retires one
// multiplier bit; o_product is the accumulator value after the current step.
module seq_alu_mul #(
    parameter int WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_load,
    input  logic                 i_step,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_last,
    output logic [2*WIDTH-1:0]   o_product
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mcand;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH:0]     w_partial;

    // High half plus multiplicand keeps its carry, which shifts into the top bit.
    assign w_partial = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
    assign o_product = {w_partial, r_acc[WIDTH-1:1]};
    assign o_last    = i_step && (r_cnt == CW'(WIDTH-1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc   <= '0;
            r_mcand <= '0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_acc   <= {{WIDTH{1'b0}}, i_b};
            r_mcand <= i_a;
            r_cnt   <= '0;
        end else if (i_step) begin
            r_acc   <= o_product;
            r_cnt   <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU feeding the CPU flag register; START/BUSY/DONE handshake.
// Define SEQ_ALU_MUL_EN to build the multi-cycle MUL opcode and its multiplier.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [3:0]       OP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic [WIDTH-1:0] RESULT_HI,
    output logic [3:0]       Flags,
    output logic             FWE
);
    import seq_alu_pkg::*;

    localparam int MSB = WIDTH - 1;

    state_t           r_state;
    logic             r_done;
    logic             r_fwe;
    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_flags;

    logic             w_add_cin;
    logic             w_sub_cin;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_res;
    logic             w_cf;
    logic             w_of;
    logic [3:0]       w_flags;
    logic             w_wr_flags;
    logic             w_wr_res;

    assign w_add_cin = (OP == OP_ADC) && CIN;
    assign w_sub_cin = (OP == OP_SBB) && CIN;
    assign w_sum     = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, w_add_cin};
    assign w_diff    = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, w_sub_cin};

    assign w_wr_flags = op_writes_flags(OP);
    assign w_wr_res   = w_wr_flags && (OP != OP_CMP);

    always_comb begin
        w_res = r_result;
        w_cf  = 1'b0;
        w_of  = 1'b0;
        case (OP)
            OP_ADD, OP_ADC: begin
                w_res = w_sum[MSB:0];
                w_cf  = w_sum[WIDTH];
                w_of  = (A[MSB] == B[MSB]) && (w_sum[MSB] != A[MSB]);
            end
            OP_SUB, OP_SBB, OP_CMP: begin
                w_res = w_diff[MSB:0];
                w_cf  = w_diff[WIDTH];
                w_of  = (A[MSB] != B[MSB]) && (w_diff[MSB] != A[MSB]);
            end
            OP_AND: w_res = A & B;
            OP_OR:  w_res = A | B;
            OP_XOR: w_res = A ^ B;
            OP_NOT: w_res = ~A;
            OP_SHL: begin
                w_res = {A[MSB-1:0], 1'b0};
                w_cf  = A[MSB];
                w_of  = A[MSB] ^ A[MSB-1];
            end
            OP_SHR: begin
                w_res = {1'b0, A[MSB:1]};
                w_cf  = A[0];
            end
            default: w_res = r_result;
        endcase
        w_flags          = '0;
        w_flags[FLAG_CF] = w_cf;
        w_flags[FLAG_OF] = w_of;
        w_flags[FLAG_NF] = w_res[MSB];
        w_flags[FLAG_ZF] = (w_res == '0);
    end

`ifdef SEQ_ALU_MUL_EN
    logic [WIDTH-1:0]   r_result_hi;
    logic               w_mul_load;
    logic               w_mul_last;
    logic [2*WIDTH-1:0] w_prod;
    logic [3:0]         w_mul_flags;

    assign w_mul_load = (r_state == IDLE) && START && (OP == OP_MUL);

    seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
        .i_clk     (CLK),
        .i_rst     (RESET),
        .i_load    (w_mul_load),
        .i_step    (r_state == MULT),
        .i_a       (A),
        .i_b       (B),
        .o_last    (w_mul_last),
        .o_product (w_prod)
    );

    always_comb begin
        w_mul_flags          = '0;
        w_mul_flags[FLAG_CF] = (w_prod[2*WIDTH-1:WIDTH] != '0);
        w_mul_flags[FLAG_OF] = (w_prod[2*WIDTH-1:WIDTH] != '0);
        w_mul_flags[FLAG_NF] = w_prod[MSB];
        w_mul_flags[FLAG_ZF] = (w_prod == '0);
    end

    assign RESULT_HI = r_result_hi;
`else
    assign RESULT_HI = '0;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state  <= IDLE;
            r_done   <= 1'b0;
            r_fwe    <= 1'b0;
            r_result <= '0;
            r_flags  <= '0;
`ifdef SEQ_ALU_MUL_EN
            r_result_hi <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            r_fwe  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (START) begin
`ifdef SEQ_ALU_MUL_EN
                        if (OP == OP_MUL) r_state <= MULT;
                        else
`endif
                        begin
                            // Reserved opcodes still finish, but leave every output untouched.
                            r_state <= FIN;
                            r_done  <= 1'b1;
                            r_fwe   <= w_wr_flags;
                            if (w_wr_flags) r_flags  <= w_flags;
                            if (w_wr_res)   r_result <= w_res;
`ifdef SEQ_ALU_MUL_EN
                            if (w_wr_flags) r_result_hi <= '0;
`endif
                        end
                    end
                end
`ifdef SEQ_ALU_MUL_EN
                MULT: begin
                    if (w_mul_last) begin
                        r_state     <= FIN;
                        r_done      <= 1'b1;
                        r_fwe       <= 1'b1;
                        r_result    <= w_prod[MSB:0];
                        r_result_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_flags     <= w_mul_flags;
                    end
                end
`endif
                FIN:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign BUSY   = (r_state != IDLE);
    assign DONE   = r_done;
    assign FWE    = r_fwe;
    assign RESULT = r_result;
    assign Flags  = r_flags;

endmodule

// File: tb/tb_seq_alu.sv
// Randomized self-checking bench for seq_alu against an arithmetic reference model.
// Honours SEQ_ALU_MUL_EN the same way as the design.
module tb_seq_alu;

    localparam int W = 8;
`ifdef SEQ_ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         CLK = 1'b0;
    logic         RESET;
    logic         START;
    logic [3:0]   OP;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         CIN;
    logic         BUSY;
    logic         DONE;
    logic [W-1:0] RESULT;
    logic [W-1:0] RESULT_HI;
    logic [3:0]   Flags;
    logic         FWE;

    seq_alu #(.WIDTH(W)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .START     (START),
        .OP        (OP),
        .A         (A),
        .B         (B),
        .CIN       (CIN),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .RESULT    (RESULT),
        .RESULT_HI (RESULT_HI),
        .Flags     (Flags),
        .FWE       (FWE)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int exp_res, exp_hi, exp_flags;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
        end
    endtask

    function automatic int sgn(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    // Updates the expected architectural outputs; returns latency and FWE.
    task automatic model(input int op, input int a, input int b, input int c,
                         output int lat, output int fwe);
        int r, s, cf, of, p;
        bit wr_res;
        lat = 1; fwe = 1; wr_res = 1; cf = 0; of = 0; r = 0;
        case (op)
            0, 1: begin
                s  = a + b + ((op == 1) ? c : 0);
                r  = s & 255;
                cf = (s > 255);
                s  = sgn(a) + sgn(b) + ((op == 1) ? c : 0);
                of = (s > 127) || (s < -128);
            end
            2, 3, 11: begin
                s  = a - b - ((op == 3) ? c : 0);
                r  = s & 255;
                cf = (s < 0);
                s  = sgn(a) - sgn(b) - ((op == 3) ? c : 0);
                of = (s > 127) || (s < -128);
                wr_res = (op != 11);
            end
            4: r = a & b;
            5: r = a | b;
            6: r = a ^ b;
            7: r = (~a) & 255;
            8: begin r = (a << 1) & 255; cf = (a >> 7) & 1; of = ((a >> 7) ^ (a >> 6)) & 1; end
            9: begin r = a >> 1; cf = a & 1; end
            10: fwe = MUL_EN;
            default: fwe = 0;
        endcase
        if (op == 10 && MUL_EN) begin
            p = a * b;
            lat = W + 1;
            exp_res = p & 255;
            exp_hi = p >> 8;
            exp_flags = ((exp_hi != 0) ? 12 : 0) + (((exp_res >> 7) & 1) * 2) + ((p == 0) ? 1 : 0);
        end else if (fwe != 0) begin
            if (wr_res) exp_res = r;
            exp_hi = 0;
            exp_flags = cf * 8 + of * 4 + ((r >> 7) & 1) * 2 + ((r == 0) ? 1 : 0);
        end
    endtask

    // One transaction; with hold set, START stays high and inputs churn while busy.
    task automatic do_op(input int op, input int a, input int b, input int c, input bit hold);
        int lat, want_lat, want_fwe;
        @(negedge CLK);
        OP = op[3:0]; A = a[W-1:0]; B = b[W-1:0]; CIN = c[0]; START = 1'b1;
        model(op, a, b, c, want_lat, want_fwe);
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
            if (!hold) START = 1'b0;
            else if (!DONE) begin
                OP = 4'($urandom_range(0, 15)); A = 8'($urandom); B = 8'($urandom); CIN = 1'($urandom);
            end
        end while (!DONE && lat < 30);
        chk($sformatf("latency op%0d", op), lat, want_lat);
        chk($sformatf("done op%0d", op), DONE, 1);
        chk($sformatf("busy_fin op%0d", op), BUSY, 1);
        chk($sformatf("fwe op%0d", op), FWE, want_fwe);
        chk($sformatf("result op%0d a=%0h b=%0h", op, a, b), RESULT, exp_res);
        chk($sformatf("result_hi op%0d", op), RESULT_HI, exp_hi);
        chk($sformatf("flags op%0d a=%0h b=%0h c=%0d", op, a, b, c), Flags, exp_flags);
        START = 1'b0;
        @(negedge CLK);
        chk($sformatf("done_pulse op%0d", op), DONE, 0);
        chk($sformatf("fwe_pulse op%0d", op), FWE, 0);
        chk($sformatf("idle op%0d", op), BUSY, 0);
    endtask

    function automatic int pick_operand();
        int sel;
        sel = $urandom_range(0, 7);
        case (sel)
            0: return 8'h00;
            1: return 8'h7F;
            2: return 8'h80;
            3: return 8'hFF;
            default: return $urandom_range(0, 255);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        RESET = 1'b1; START = 1'b0; OP = '0; A = '0; B = '0; CIN = 1'b0;
        exp_res = 0; exp_hi = 0; exp_flags = 0;
        repeat (2) @(negedge CLK);
        chk("rst_result", RESULT, 0);
        chk("rst_result_hi", RESULT_HI, 0);
        chk("rst_flags", Flags, 0);
        chk("rst_done", DONE, 0);
        chk("rst_fwe", FWE, 0);
        chk("rst_busy", BUSY, 0);
        RESET = 1'b0;

        do_op(0, 'h7F, 'h01, 0, 0);
        chk("add_lit_result", RESULT, 8'h80);
        chk("add_lit_flags", Flags, 4'b0110);
        do_op(2, 'h00, 'h01, 0, 0);
        chk("sub_lit_flags", Flags, 4'b1010);
        do_op(0, 'h12, 'h34, 0, 0);
        do_op(11, 'h00, 'h01, 0, 0);
        chk("cmp_lit_flags", Flags, 4'b1010);
        chk("cmp_lit_keeps_result", RESULT, 8'h46);
        do_op(1, 'hFF, 'h00, 1, 0);
        chk("adc_lit_result", RESULT, 8'h00);
        chk("adc_lit_flags", Flags, 4'b1001);
        do_op(3, 'h80, 'h00, 1, 0);
        do_op(8, 'h40, 'h00, 0, 0);
        do_op(9, 'h01, 'h00, 0, 0);
        do_op(10, 'h10, 'h10, 0, 1);
        do_op(13, 'h55, 'hAA, 1, 0);
        do_op(10, 'hFF, 'hFF, 0, 0);
        do_op(12, 'h00, 'h00, 0, 1);

        // Abort mid-operation with an asynchronous reset.
        do_op(0, 'h7F, 'h01, 0, 0);
        @(negedge CLK);
        OP = 4'd10; A = 8'h10; B = 8'h10; CIN = 1'b0; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (3) @(negedge CLK);
        chk("busy_mid_mul", BUSY, MUL_EN ? 1 : 0);
        #1 RESET = 1'b1;
        #1;
        chk("arst_result", RESULT, 0);
        chk("arst_result_hi", RESULT_HI, 0);
        chk("arst_flags", Flags, 0);
        chk("arst_busy", BUSY, 0);
        chk("arst_done", DONE, 0);
        chk("arst_fwe", FWE, 0);
        exp_res = 0; exp_hi = 0; exp_flags = 0;
        @(negedge CLK);
        RESET = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge CLK);
            if (DONE || FWE) seen++;
        end
        chk("no_done_after_abort", seen, 0);
        do_op(0, 'h12, 'h34, 0, 0);

        for (int i = 0; i < 300; i++) begin
            do_op($urandom_range(0, 15), pick_operand(), pick_operand(),
                  $urandom_range(0, 1), ($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Sequential 8-bit ALU sitting directly upstream of the CPU flag register.
- Computes the result and the 4-bit flag vector {CF,OF,NF,ZF}, then pulses FWE to load it.
- Single-cycle ops complete in 1 cycle. MUL is a multi-cycle shift-add op handled by a START/BUSY/DONE handshake with the control unit.

Parameters:
WIDTH, 8, operand/result width in bits (MUL iterates WIDTH cycles)

Ports:
CLK  input  1  system clock, rising edge
RESET  input  1  asynchronous, active-high reset
START  input  1  begin operation; sampled only when BUSY=0
OP  input  4  opcode, captured with START
A  input  WIDTH  operand A, captured with START
B  input  WIDTH  operand B, captured with START
CIN  input  1  carry-in (fed from CF), captured with START
BUSY  output  1  high whenever FSM not in IDLE
DONE  output  1  one-cycle pulse, result valid
RESULT  output  WIDTH  result (low half for MUL)
RESULT_HI  output  WIDTH  MUL high half; 0 for all other ops
Flags  output  4  {CF,OF,NF,ZF}; bit3=CF, bit2=OF, bit1=NF, bit0=ZF
FWE  output  1  flag write enable to flag register; one-cycle pulse coincident with DONE

Behaviour:
- Reset (asynchronous, active-high): RESULT=0, RESULT_HI=0, Flags=0, FWE=0, DONE=0, BUSY=0, FSM=IDLE. Asserting RESET mid-MUL aborts the op; no DONE/FWE is issued for it.
- FSM states: IDLE, MULT, FIN.
  - IDLE & START & single-cycle op -> FIN
  - IDLE & START & MUL -> MULT
  - MULT: counter runs WIDTH cycles -> FIN
  - FIN -> IDLE unconditionally
- START while BUSY=1 is ignored. OP, A, B and CIN are latched at the accepting edge; later changes have no effect.
- Latency, START edge to DONE: single-cycle op = 1 cycle, MUL = WIDTH+1 cycles (9 at default).
- DONE and FWE are high only in FIN. RESULT, RESULT_HI and Flags are registered and hold until the next FIN or RESET.
- Opcodes:
  - 0 ADD: A+B
  - 1 ADC: A+B+CIN
  - 2 SUB: A-B
  - 3 SBB: A-B-CIN
  - 4 AND
  - 5 OR
  - 6 XOR
  - 7 NOT A
  - 8 SHL: A<<1
  - 9 SHR: A>>1 logical
  - 10 MUL: unsigned A*B, 2*WIDTH-bit product
  - 11 CMP: SUB flags only, RESULT unchanged
  - 12-15 reserved
- Flag rules:
  - ZF = (RESULT==0); for MUL, ZF = (full product == 0).
  - NF = RESULT[WIDTH-1].
  - ADD/ADC: CF = carry out of the WIDTH+1-bit sum; OF = signed overflow (operands same sign, result sign differs).
  - SUB/SBB/CMP: CF = borrow (unsigned A < B+CIN); OF = signed overflow (operand signs differ, result sign differs from A).
  - AND/OR/XOR/NOT: CF=0, OF=0.
  - SHL: CF=A[WIDTH-1], OF=A[WIDTH-1]^A[WIDTH-2].
  - SHR: CF=A[0], OF=0.
  - MUL: CF=OF=(RESULT_HI!=0).
- Reserved op: goes to FIN and pulses DONE. FWE=0; RESULT, RESULT_HI and Flags are unchanged.
- Sum/difference arithmetic is computed WIDTH+1 bits wide, never truncated before CF extraction.
- START in the FIN cycle is ignored (BUSY=1); accepted no earlier than the following IDLE cycle.

Optional Feature:
SEQ_ALU_MUL_EN
- Defined: opcode 10 MUL implemented as above; MULT state and multiplier present.
- Undefined: MUL logic and MULT state removed. Opcode 10 treated as reserved (1-cycle DONE, FWE=0). RESULT_HI tied to 0.

Decomposition:
- Shared package seq_alu_pkg holds:
  - opcode localparams (OP_ADD..OP_CMP)
  - flag bit indices (FLAG_CF=3, FLAG_OF=2, FLAG_NF=1, FLAG_ZF=0)
  - FSM state encoding (IDLE, MULT, FIN)
- One sub-module: seq_alu_mul.
  - Shift-add unsigned multiplier core with load/step inputs, WIDTH-cycle iteration, 2*WIDTH-bit product output.
  - Instantiated only under SEQ_ALU_MUL_EN.

Test Plan:
- ADD A=0x7F B=0x01 START -> next cycle DONE=FWE=1, RESULT=0x80, Flags=4'b0110.
- SUB A=0x00 B=0x01 -> RESULT=0xFF, Flags=4'b1010; CMP with the same operands -> Flags=4'b1010, RESULT keeps prior value.
- ADC A=0xFF B=0x00 CIN=1 -> RESULT=0x00, Flags=4'b1001.
- MUL A=0x10 B=0x10 -> BUSY high 9 cycles; DONE on cycle 9 after START; RESULT=0x00, RESULT_HI=0x01, Flags=4'b1100. Second START pulsed during BUSY is ignored (exactly one DONE).
- RESET asserted at MUL cycle 4 -> all outputs 0 immediately (async), BUSY=0, no DONE/FWE; a fresh ADD afterwards completes normally.
- OP=13 START -> DONE=1, FWE=0, Flags/RESULT unchanged. With SEQ_ALU_MUL_EN undefined, OP=10 behaves identically.
